// File: rtl/md_unit_pkg.sv
// Shared op encodings, FSM state encodings and small helpers for the HI/LO
// multiply/divide unit. Imported by the decoder and by md_unit.
package md_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } md_state_e;

  localparam int unsigned DIV_ITERS = 32;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_unit_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per cycle,
// DIV_ITERS cycles after go. Divide by zero naturally yields all-ones/dividend.
module div_core
  import md_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic [5:0]  r_cnt;
  logic [32:0] w_trial;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  assign w_trial   = {r_rem, r_quo[31]} - {1'b0, r_dvs};
  assign quotient  = r_quo;
  assign remainder = r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
    end else if (go) begin
      r_quo <= dividend;
      r_rem <= '0;
      r_dvs <= divisor;
      r_cnt <= 6'(DIV_ITERS);
    end else if (r_cnt != 6'd0) begin
      r_cnt <= r_cnt - 6'd1;
      if (!w_trial[32]) begin
        r_rem <= w_trial[31:0];
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= {r_rem[30:0], r_quo[31]};
        r_quo <= {r_quo[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: sequencing FSM, two-stage multiply, divide sign
// handling and the architectural HI/LO registers.
//   state | meaning
//   IDLE  | ready; MTHI/MTLO complete here in one edge
//   MUL   | two cycles: operand register, then product register
//   DIV   | 32 restoring iterations running in div_core
//   FIX   | apply sign correction and write HI/LO
module md_unit
  import md_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  md_state_e   r_state, w_state_nxt;
  logic        r_mul_cnt;
  logic [4:0]  r_div_cnt;
  logic [63:0] r_ma, r_mb, r_prod;
  logic        r_neg_q, r_neg_r;
  logic        w_done;

  logic        w_accept, w_is_mul, w_is_div, w_mthi, w_mtlo, w_signed_div;
  logic [63:0] w_prod;
  logic [31:0] w_dvd, w_dvs, w_quo, w_rem;

  assign w_accept     = start && !flush && (r_state == ST_IDLE);
  assign w_is_mul     = w_accept && (op == OP_MULT || op == OP_MULTU);
  assign w_is_div     = w_accept && (op == OP_DIV || op == OP_DIVU);
  assign w_mthi       = w_accept && (op == OP_MTHI);
  assign w_mtlo       = w_accept && (op == OP_MTLO);
  assign w_signed_div = (op == OP_DIV);

  assign w_dvd  = w_signed_div ? abs32(a) : a;
  assign w_dvs  = w_signed_div ? abs32(b) : b;
  // Operands are pre-extended to 64 bits, so the low 64 product bits are exact.
  assign w_prod = r_ma * r_mb;

  div_core u_div_core (
    .clk       (clk),
    .rst       (rst),
    .go        (w_is_div),
    .dividend  (w_dvd),
    .divisor   (w_dvs),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mul)      w_state_nxt = ST_MUL;
        else if (w_is_div) w_state_nxt = ST_DIV;
      end
      ST_MUL: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (r_mul_cnt) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end
      end
      ST_DIV: begin
        if (flush)                 w_state_nxt = ST_IDLE;
        else if (r_div_cnt == 5'd0) w_state_nxt = ST_FIX;
      end
      ST_FIX: begin
        w_state_nxt = ST_IDLE;
        w_done      = !flush;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign done = w_done && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      busy      <= 1'b0;
      r_mul_cnt <= 1'b0;
      r_div_cnt <= '0;
      r_ma      <= '0;
      r_mb      <= '0;
      r_prod    <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt != ST_IDLE);

      if (w_is_mul) begin
        r_ma      <= (op == OP_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
        r_mb      <= (op == OP_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
        r_mul_cnt <= 1'b0;
      end
      if (r_state == ST_MUL) begin
        r_mul_cnt <= 1'b1;
        r_prod    <= w_prod;
      end

      if (w_is_div) begin
        r_div_cnt <= 5'(DIV_ITERS - 1);
        r_neg_q   <= w_signed_div && (a[31] ^ b[31]);
        r_neg_r   <= w_signed_div && a[31];
      end else if (r_state == ST_DIV && r_div_cnt != 5'd0) begin
        r_div_cnt <= r_div_cnt - 5'd1;
      end

      if (w_mthi) hi <= a;
      if (w_mtlo) lo <= a;
      if (w_done) begin
        if (r_state == ST_MUL) begin
          hi <= r_prod[63:32];
          lo <= r_prod[31:0];
        end else begin
          hi <= neg_if(w_rem, r_neg_r);
          lo <= neg_if(w_quo, r_neg_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: MT moves, multiply, divide corner
// cases, flush cancellation and mid-operation reset.
module tb_md_unit;

  localparam logic [2:0] C_MULT  = 3'b000;
  localparam logic [2:0] C_MULTU = 3'b001;
  localparam logic [2:0] C_DIV   = 3'b010;
  localparam logic [2:0] C_DIVU  = 3'b011;
  localparam logic [2:0] C_MTHI  = 3'b100;
  localparam logic [2:0] C_MTLO  = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b111;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;
  logic        done;

  int errors = 0;
  int checks = 0;

  md_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Present a request for one edge; returns just after the accepting edge T.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo);
    end
    rst = 1'b0;
  endtask

  task automatic test_mt;
    int busy_seen;
    busy_seen = 0;
    issue(C_MTHI, 32'h12345678, 32'h0);
    @(negedge clk);
    if (busy || done) busy_seen++;
    issue(C_MTLO, 32'h9ABCDEF0, 32'h0);
    @(negedge clk);
    if (busy || done) busy_seen++;
    checks++;
    if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL mt_write: hi=%h lo=%h, required 12345678/9abcdef0", hi, lo);
    end
    checks++;
    if (busy_seen !== 0) begin
      errors++;
      $display("FAIL mt_busy: busy/done seen %0d times, required 0", busy_seen);
    end
  endtask

  task automatic test_mul(input string nm, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] exp);
    issue(o, av, bv);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_t1: busy=%b done=%b, required 1/0", nm, busy, done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL %s_t2: busy=%b done=%b, required 1/1", nm, busy, done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== exp) begin
      errors++;
      $display("FAIL %s_t3: busy=%b done=%b hilo=%h, required 0/0 %h", nm, busy, done, {hi, lo}, exp);
    end
  endtask

  task automatic test_div(input string nm, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int busy_cyc, ndone, done_at;
    busy_cyc = 0; ndone = 0; done_at = -1;
    issue(o, av, bv);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cyc++;
      if (done) begin
        ndone++;
        done_at = busy_cyc;
      end
    end
    checks++;
    if (busy_cyc != 33 || ndone != 1 || done_at != 33) begin
      errors++;
      $display("FAIL %s_timing: busy_cycles=%0d done_pulses=%0d done_at=%0d, required 33/1/33",
               nm, busy_cyc, ndone, done_at);
    end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL %s_result: hi=%h lo=%h, required %h/%h", nm, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_flush_div;
    int ndone;
    ndone = 0;
    issue(C_MTHI, 32'hAAAA0001, 32'h0);
    issue(C_MTLO, 32'hBBBB0002, 32'h0);
    issue(C_DIV, 32'd1000, 32'd7);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    if (done) ndone++;
    checks++;
    if (busy !== 1'b0 || hi !== 32'hAAAA0001 || lo !== 32'hBBBB0002 || ndone != 0) begin
      errors++;
      $display("FAIL flush_div: busy=%b hi=%h lo=%h done_pulses=%0d, required 0 aaaa0001 bbbb0002 0",
               busy, hi, lo, ndone);
    end
    // Restart in the very cycle after the flush: 1000/7 = 142 r 6.
    op = C_DIV; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd6 || lo !== 32'd142) begin
      errors++;
      $display("FAIL flush_restart: busy=%b hi=%h lo=%h, required 0 6 142", busy, hi, lo);
    end
  endtask

  task automatic test_flush_mul;
    logic done_seen;
    issue(C_MTHI, 32'h0000_1111, 32'h0);
    issue(C_MULTU, 32'd6, 32'd7);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1 done_seen = done;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (done_seen !== 1'b0 || busy !== 1'b0 || hi !== 32'h0000_1111 || lo !== 32'd142) begin
      errors++;
      $display("FAIL flush_mul: done=%b busy=%b hi=%h lo=%h, required 0 0 00001111 0000008e",
               done_seen, busy, hi, lo);
    end
  endtask

  task automatic test_rst_mid;
    issue(C_MULTU, 32'd5, 32'd7);
    @(negedge clk);
    op = C_MTHI; a = 32'hDEADBEEF; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd35) begin
      errors++;
      $display("FAIL ignored_start: busy=%b hi=%h lo=%h, required 0 0 35", busy, hi, lo);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL rst_after_mul: busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo);
    end
    issue(C_DIVU, 32'd50, 32'd3);
    repeat (6) @(negedge clk);
    rst = 1'b1; start = 1'b1; op = C_MTHI; a = 32'h55;
    @(posedge clk);
    #1 begin rst = 1'b0; start = 1'b0; end
    @(negedge clk);
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL rst_mid_div: busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo);
    end
    test_div("div_after_rst", C_DIVU, 32'd9, 32'd2, 32'd1, 32'd4);
  endtask

  initial begin
    test_reset();
    test_mt();
    test_mul("mult", C_MULT, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA);
    test_mul("multu", C_MULTU, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA);
    test_mul("mult_min", C_MULT, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    test_mul("multu_max", C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    test_div("div_neg7", C_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    test_div("div_negb", C_DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2);
    test_div("divu_zero", C_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
    test_div("div_zero", C_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'd1);
    test_div("div_ovf", C_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    test_div("divu_big", C_DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF);
    test_flush_div();
    test_flush_mul();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have port clk  in  1  single clock for all state; rising edge.
REQ-002 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port start  in  1  one-cycle request from EX stage.
REQ-004 SHALL have port op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others are no-op.
REQ-005 SHALL have port a  in  32  rs operand (dividend/multiplicand/MT data).
REQ-006 SHALL have port b  in  32  rt operand (divisor/multiplier).
REQ-007 SHALL have port flush  in  1  MEM1 exception/eret cancel.
REQ-008 SHALL have port busy  out  1  registered; high while a MUL/DIV is in flight; feeds the hazard unit's isbusy.
REQ-009 SHALL have port hi  out  32  architectural HI register.
REQ-010 SHALL have port lo  out  32  architectural LO register.
REQ-011 SHALL have port done  out  1  one-cycle pulse in the cycle HI/LO take a MUL/DIV result.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, FIX; busy = (state != IDLE).
REQ-013 SHALL accept start only in IDLE with flush low; start in any other state or with flush high SHALL be ignored.
REQ-014 MTHI/MTLO accepted at edge T SHALL write a to hi/lo at that edge, stay IDLE, and never assert busy or done.
REQ-015 MULT/MULTU accepted at edge T SHALL hold MUL for two cycles, write {hi,lo} = 64-bit product at edge T+2, pulse done in cycle T+2, and drop busy in cycle T+3.
REQ-016 MULT SHALL treat operands as two's-complement; MULTU SHALL treat them as unsigned; the product is the full 64 bits, with no truncation.
REQ-017 DIV/DIVU SHALL latch |a| and |b| (raw a and b for DIVU) at acceptance, run 32 radix-2 restoring iterations in DIV (one quotient bit per cycle), then enter FIX for one cycle.
REQ-018 DIV result SHALL be written at the FIX edge (T+33), with done high in cycle T+33 and busy low in cycle T+34.
REQ-019 DIV sign fix: quotient SHALL be negated iff a[31]^b[31]; remainder SHALL be negated iff a[31]. DIVU SHALL apply no sign fix.
REQ-020 Divide by zero SHALL complete with normal latency and give lo = quotient bits of all ones before the sign fix, and hi = dividend (after the sign fix).
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-022 flush high in MUL, DIV or FIX SHALL return the FSM to IDLE at that edge, leave hi/lo unchanged, and suppress done.
REQ-023 hi/lo SHALL change only via REQ-014, REQ-015 or REQ-018; busy SHALL never depend combinationally on any input.

Reset
REQ-024 rst at any edge, including mid-operation, SHALL force state IDLE, busy 0, done 0, hi 0, lo 0, and clear all iteration counters and working registers.
REQ-025 start coincident with rst SHALL be ignored.

Structure
REQ-026 op encodings and FSM state encodings SHALL live in a shared package / header used by the decoder and md_unit.
REQ-027 The iterative divider datapath SHALL be a sub-module div_core (inputs: dividend, divisor, go; outputs: quotient, remainder); the FSM, sign handling and HI/LO SHALL stay in md_unit.
REQ-028 The multiply SHALL use a two-stage registered product inside md_unit; no additional sub-module.

Verification
REQ-029 Reset, then MTHI a=0x12345678 followed by MTLO a=0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0; busy stays 0 throughout.
REQ-030 MULT a=0xFFFFFFFE, b=3 -> at T+2 {hi,lo}=0xFFFFFFFF_FFFFFFFA with done=1; busy=1 in T+1..T+2 and 0 in T+3. MULTU with the same operands -> 0x00000002_FFFFFFFA.
REQ-031 DIV a=-7 (0xFFFFFFF9), b=2 -> at T+33 lo=0xFFFFFFFD, hi=0xFFFFFFFF; busy high for exactly 33 cycles.
REQ-032 DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100 at T+33.
REQ-033 DIV started, then flush at T+10 -> busy=0 at T+11, hi/lo equal to their pre-start values, done never asserted; a new start at T+11 completes normally.
REQ-034 rst pulsed at T+5 of a MULTU, with a start asserted while busy -> the ignored start causes no effect, and all outputs read 0 the cycle after rst.
